prog_mem_loader: RTL and testbench
==================================

Name: prog_mem_loader

Overview:
- 16 x 8-bit instruction memory feeding the CPU's instruction byte input (dout), addressed combinationally by the CPU program counter (pc).
- Power-up/reset contents come from a parameter, giving a runnable default program.
- A byte-wide valid/ready load port lets a host (switch/serial front end) overwrite the program at runtime.
- While loading, the block holds the CPU in reset through a dedicated active-low reset output, so the CPU never fetches a partially written program.

Parameters:
- DEFAULT_PROG, 128'h0, reset contents; byte i = bits [8i+7:8i] = instruction at address i.
- HOLD_CYCLES, 2, cycles cpu_rst_n stays low after reset release or load completion; legal range 1..15.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- pc  input  4  CPU program counter, instruction address
- dout  output  8  instruction byte mem[pc], combinational read
- cpu_rst_n  output  1  registered active-low reset to the CPU
- ld_start  input  1  one-cycle pulse: begin a program load
- ld_valid  input  1  ld_data holds a byte
- ld_data  input  8  program byte
- ld_ready  output  1  block accepts a byte this cycle
- ld_addr  output  4  address the next accepted byte is written to
- ld_busy  output  1  a load is in progress
- ld_done  output  1  one-cycle pulse when a load completes successfully
- ld_err  output  1  sticky checksum error flag (only with the optional feature)

Behaviour:
- Reset (async assert, clk-synchronous release effect): mem <= DEFAULT_PROG, state HOLD, hold counter <= 0, cpu_rst_n = 0, ld_addr = 0, ld_ready = 0, ld_busy = 0, ld_done = 0, ld_err = 0.
- dout = mem[pc] in every state; no read latency. Write-before-read does not apply, because the CPU is held during writes.
- States:
  - HOLD: count HOLD_CYCLES clocks with cpu_rst_n = 0, then go to RUN. cpu_rst_n rises on the clock edge that enters RUN.
  - RUN: cpu_rst_n = 1. ld_start -> LOAD (cpu_rst_n <= 0 on the same edge), ld_addr <= 0.
  - LOAD: ld_ready = 1, ld_busy = 1.
    - A byte is accepted when ld_valid && ld_ready: mem[ld_addr] <= ld_data and ld_addr increments.
    - Accepting the byte at address 15 -> HOLD (without the feature) and ld_done pulses on the first cycle of HOLD.
  - CHECK: exists only with the optional feature.
- ld_start in LOAD or CHECK: restart. ld_addr <= 0, state LOAD; bytes already written are kept until overwritten. ld_start has priority over a byte offered in the same cycle (that byte is not accepted).
- ld_start in HOLD: ignored.
- ld_valid outside LOAD/CHECK: ignored, ld_ready = 0.
- ld_addr wraps 15 -> 0 only via completion. There is no wrap inside LOAD.
- Reset asserted mid-load: partial program discarded, mem <= DEFAULT_PROG, then normal HOLD -> RUN.
- ld_ready is a combinational function of state only, not of ld_valid.

Optional Feature:
- Macro: PROG_CHECKSUM_EN.
- Defined:
  - After the byte at address 15, go to CHECK (ld_ready = 1, ld_busy = 1).
  - The next accepted byte is compared with the mod-256 sum of the 16 loaded bytes, accumulated as bytes are accepted and cleared on ld_start.
  - Match -> HOLD, ld_done pulse, ld_err <= 0.
  - Mismatch -> mem <= DEFAULT_PROG, ld_err <= 1, go to HOLD (no ld_done). The CPU then runs the default program.
  - ld_err clears on the next ld_start or on reset.
- Not defined: no CHECK state, no accumulator. ld_err tied to 0.

Test Plan:
- Reset with DEFAULT_PROG byte0 = 8'hA5, byte1 = 8'h90, HOLD_CYCLES = 2 -> cpu_rst_n = 0 for exactly 2 clocks after release, then 1; pc = 0 gives dout = 8'hA5; pc = 1 gives 8'h90.
- ld_start, then 16 bytes 8'h00..8'h0F with ld_valid toggling every other cycle:
  - cpu_rst_n drops on the ld_start edge.
  - ld_addr steps 0..15 only on accepted bytes.
  - ld_done pulses once.
  - cpu_rst_n rises 2 clocks later.
  - mem[9] read via pc = 9 gives 8'h09.
- Load interrupted after 5 bytes by ld_start, then 16 bytes 8'hF0..8'hFF -> final mem[i] = 8'hF0+i; a ld_valid asserted in the ld_start cycle is not accepted (ld_addr = 0 afterwards).
- Reset asserted after 7 load bytes -> dout for pc = 0..15 equals DEFAULT_PROG; cpu_rst_n = 0 for HOLD_CYCLES, then 1; ld_busy = 0.
- PROG_CHECKSUM_EN, bytes 8'h10 x16 with checksum 8'h00 -> ld_done pulses, ld_err = 0, mem loaded.
- PROG_CHECKSUM_EN, same bytes with checksum 8'h01 -> ld_err = 1, no ld_done, mem = DEFAULT_PROG, CPU released after HOLD_CYCLES.

Source files
------------

// File: rtl/prog_mem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prog_mem_loader                                              |
// | Description : 16 x 8-bit CPU instruction memory with a byte-wide           |
// |               valid/ready load port. The CPU is held in reset through      |
// |               cpu_rst_n while a new program is written and for             |
// |               HOLD_CYCLES clocks after reset release or load completion.   |
// | Option      : `define PROG_CHECKSUM_EN adds a trailing mod-256 checksum     |
// |               byte after the 16 program bytes. A bad checksum restores     |
// |               DEFAULT_PROG and sets the sticky ld_err flag.                |
// | Ports       : clk, reset   - clock, asynchronous active-high reset         |
// |               pc / dout    - CPU fetch address / combinational read data   |
// |               cpu_rst_n    - registered active-low CPU reset               |
// |               ld_start     - pulse: begin (or restart) a program load      |
// |               ld_valid/ld_data/ld_ready - byte handshake                   |
// |               ld_addr      - address the next accepted byte goes to        |
// |               ld_busy      - load in progress                              |
// |               ld_done      - one-cycle pulse on successful completion      |
// |               ld_err       - sticky checksum error (0 without the option)  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module prog_mem_loader #(
   parameter logic [127:0] DEFAULT_PROG = 128'h0,
   parameter int unsigned  HOLD_CYCLES  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] pc,
   output logic [7:0] dout,
   output logic       cpu_rst_n,
   input  logic       ld_start,
   input  logic       ld_valid,
   input  logic [7:0] ld_data,
   output logic       ld_ready,
   output logic [3:0] ld_addr,
   output logic       ld_busy,
   output logic       ld_done,
   output logic       ld_err
);

   // Counter value on which HOLD hands over to RUN; the counter starts at 0
   // on HOLD entry so HOLD lasts exactly HOLD_CYCLES clocks.
   localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
   localparam logic [3:0] LAST_ADDR = 4'd15;

   typedef enum logic [1:0] {
      ST_HOLD  = 2'd0,
      ST_RUN   = 2'd1,
`ifdef PROG_CHECKSUM_EN
      ST_LOAD  = 2'd2,
      ST_CHECK = 2'd3
`else
      ST_LOAD  = 2'd2
`endif
   } state_t;

   state_t         state_q,     state_d;
   logic [3:0]     hold_cnt_q,  hold_cnt_d;
   logic [127:0]   mem_q,       mem_d;
   logic [3:0]     ld_addr_q,   ld_addr_d;
   logic           cpu_rst_n_q, cpu_rst_n_d;
   logic           ld_done_q,   ld_done_d;
`ifdef PROG_CHECKSUM_EN
   logic [7:0]     sum_q,       sum_d;
   logic           ld_err_q,    ld_err_d;
`endif

   // ------------------------------------------------------------------------
   // Handshake qualifiers: the port is open purely as a function of state.
   // ------------------------------------------------------------------------
   logic port_open;

`ifdef PROG_CHECKSUM_EN
   assign port_open = (state_q == ST_LOAD) || (state_q == ST_CHECK);
`else
   assign port_open = (state_q == ST_LOAD);
`endif

   // ------------------------------------------------------------------------
   // Next-state, memory write and handshake bookkeeping.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = '0;
      mem_d      = mem_q;
      ld_addr_d  = ld_addr_q;
      ld_done_d  = 1'b0;
`ifdef PROG_CHECKSUM_EN
      sum_d      = sum_q;
      ld_err_d   = ld_err_q;
`endif

      case (state_q)
         ST_HOLD: begin
            // ld_start is deliberately ignored here: the previous program
            // is already committed and the CPU is about to be released.
            if (hold_cnt_q == HOLD_LAST) begin
               state_d = ST_RUN;
            end else begin
               hold_cnt_d = hold_cnt_q + 4'd1;
            end
         end

         ST_RUN: begin
            if (ld_start) begin
               state_d   = ST_LOAD;
               ld_addr_d = '0;
`ifdef PROG_CHECKSUM_EN
               sum_d     = '0;
               ld_err_d  = 1'b0;
`endif
            end
         end

         ST_LOAD: begin
            // Restart wins over a byte offered in the same cycle; bytes
            // already written stay until overwritten by the new pass.
            if (ld_start) begin
               ld_addr_d = '0;
`ifdef PROG_CHECKSUM_EN
               sum_d     = '0;
               ld_err_d  = 1'b0;
`endif
            end else if (ld_valid) begin
               mem_d[{ld_addr_q, 3'b000} +: 8] = ld_data;
               // Wraps to 0 only on the final byte, which also leaves LOAD.
               ld_addr_d = ld_addr_q + 4'd1;
`ifdef PROG_CHECKSUM_EN
               sum_d     = sum_q + ld_data;
`endif
               if (ld_addr_q == LAST_ADDR) begin
`ifdef PROG_CHECKSUM_EN
                  state_d   = ST_CHECK;
`else
                  state_d   = ST_HOLD;
                  ld_done_d = 1'b1;
`endif
               end
            end
         end

`ifdef PROG_CHECKSUM_EN
         ST_CHECK: begin
            if (ld_start) begin
               state_d   = ST_LOAD;
               ld_addr_d = '0;
               sum_d     = '0;
               ld_err_d  = 1'b0;
            end else if (ld_valid) begin
               state_d = ST_HOLD;
               if (ld_data == sum_q) begin
                  ld_done_d = 1'b1;
                  ld_err_d  = 1'b0;
               end else begin
                  // Never let the CPU run a program that failed its check.
                  mem_d    = DEFAULT_PROG;
                  ld_err_d = 1'b1;
               end
            end
         end
`endif

         default: begin
            state_d = ST_HOLD;
         end
      endcase

      // Registered CPU reset: released on exactly the edge that enters RUN
      // and pulled low on the edge that leaves it.
      cpu_rst_n_d = (state_d == ST_RUN);
   end

   // ------------------------------------------------------------------------
   // State registers.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_HOLD;
         hold_cnt_q  <= '0;
         mem_q       <= DEFAULT_PROG;
         ld_addr_q   <= '0;
         cpu_rst_n_q <= 1'b0;
         ld_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         mem_q       <= mem_d;
         ld_addr_q   <= ld_addr_d;
         cpu_rst_n_q <= cpu_rst_n_d;
         ld_done_q   <= ld_done_d;
      end
   end

`ifdef PROG_CHECKSUM_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum_q    <= '0;
         ld_err_q <= 1'b0;
      end else begin
         sum_q    <= sum_d;
         ld_err_q <= ld_err_d;
      end
   end

   assign ld_err = ld_err_q;
`else
   assign ld_err = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Outputs.
   // ------------------------------------------------------------------------
   assign dout      = mem_q[{pc, 3'b000} +: 8];
   assign cpu_rst_n = cpu_rst_n_q;
   assign ld_ready  = port_open;
   assign ld_busy   = port_open;
   assign ld_addr   = ld_addr_q;
   assign ld_done   = ld_done_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_mem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_prog_mem_loader                                           |
// | Description : Scoreboard testbench for prog_mem_loader. Stimulus pushes    |
// |               expected accept addresses, done pulses and read data into    |
// |               queues; a negedge monitor pops and compares them.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_prog_mem_loader;

   localparam logic [127:0] DEF  = 128'h00112233445566778899AABBCCDD90A5;
   localparam int           HOLD = 2;

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   logic [3:0] pc       = '0;
   logic       ld_start = 1'b0;
   logic       ld_valid = 1'b0;
   logic [7:0] ld_data  = '0;
   logic [7:0] dout;
   logic       cpu_rst_n;
   logic       ld_ready;
   logic [3:0] ld_addr;
   logic       ld_busy;
   logic       ld_done;
   logic       ld_err;

   prog_mem_loader #(
      .DEFAULT_PROG (DEF),
      .HOLD_CYCLES  (HOLD)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .pc        (pc),
      .dout      (dout),
      .cpu_rst_n (cpu_rst_n),
      .ld_start  (ld_start),
      .ld_valid  (ld_valid),
      .ld_data   (ld_data),
      .ld_ready  (ld_ready),
      .ld_addr   (ld_addr),
      .ld_busy   (ld_busy),
      .ld_done   (ld_done),
      .ld_err    (ld_err)
   );

   always #5 clk = ~clk;

   // Reference model and scoreboard state
   int         n_cmp    = 0;
   int         n_bad    = 0;
   logic [7:0] model [16];
   logic [7:0] pbuf  [16];
   logic [3:0] acc_q [$];
   logic [7:0] rd_q  [$];
   int         done_exp = 0;
   logic       rd_req   = 1'b0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] def_byte(input int i);
      logic [127:0] v;
      v = DEF;
      return v[i*8 +: 8];
   endfunction

   task automatic model_default();
      for (int i = 0; i < 16; i++) model[i] = def_byte(i);
   endtask

   // ------------------------------------------------------------------------
   // Monitor: pops expectations whenever the DUT shows an output event.
   // ------------------------------------------------------------------------
   always @(negedge clk) begin
      if (!reset) begin
         if (ld_valid && ld_ready && !ld_start) begin
            if (acc_q.size() > 0) cmp("accept_addr", 32'(ld_addr), 32'(acc_q.pop_front()));
            else cmp("accept_expected", 32'(acc_q.size()), 32'd1);
         end
         if (ld_done) begin
            if (done_exp > 0) begin
               done_exp--;
               cmp("done_err", 32'(ld_err), 32'd0);
            end else begin
               cmp("done_expected", 32'(done_exp), 32'd1);
            end
         end
      end
      if (rd_req) begin
         if (rd_q.size() > 0) cmp("dout", 32'(dout), 32'(rd_q.pop_front()));
         else cmp("rd_queue", 32'(rd_q.size()), 32'd1);
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered #1 after the edge that put the DUT into HOLD (or reset release).
   task automatic hold_check(input string tag, input bit poke);
      cmp({tag, "_rstn_low0"}, 32'(cpu_rst_n), 32'd0);
      cmp({tag, "_busy"}, 32'(ld_busy), 32'd0);
      if (poke) ld_start = 1'b1;
      for (int i = 1; i < HOLD; i++) begin
         tick();
         ld_start = 1'b0;
         cmp({tag, "_rstn_low"}, 32'(cpu_rst_n), 32'd0);
      end
      tick();
      ld_start = 1'b0;
      cmp({tag, "_rstn_high"}, 32'(cpu_rst_n), 32'd1);
      cmp({tag, "_busy_run"}, 32'(ld_busy), 32'd0);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      ld_start = 1'b0;
      ld_valid = 1'b0;
      model_default();
      #1;
      cmp("rst_rstn", 32'(cpu_rst_n), 32'd0);
      cmp("rst_ready", 32'(ld_ready), 32'd0);
      cmp("rst_busy", 32'(ld_busy), 32'd0);
      cmp("rst_addr", 32'(ld_addr), 32'd0);
      cmp("rst_done", 32'(ld_done), 32'd0);
      cmp("rst_err", 32'(ld_err), 32'd0);
      tick();
      tick();
      reset = 1'b0;
      hold_check("reset", 1'b0);
   endtask

   task automatic wait_run();
      int n = 0;
      while (!cpu_rst_n && n < 40) begin
         tick();
         n++;
      end
      cmp("run_reached", 32'(cpu_rst_n), 32'd1);
   endtask

   // Pulse ld_start; optionally offer a byte in the same cycle (must be dropped).
   task automatic start_load(input bit with_valid);
      ld_start = 1'b1;
      ld_valid = with_valid;
      ld_data  = 8'($urandom);
      tick();
      ld_start = 1'b0;
      ld_valid = 1'b0;
      cmp("start_rstn", 32'(cpu_rst_n), 32'd0);
      cmp("start_busy", 32'(ld_busy), 32'd1);
      cmp("start_ready", 32'(ld_ready), 32'd1);
      cmp("start_addr", 32'(ld_addr), 32'd0);
      cmp("start_err", 32'(ld_err), 32'd0);
   endtask

   task automatic send_raw(input logic [3:0] exp_addr, input logic [7:0] b,
                           input int gap, input bit exp_done);
      repeat (gap) tick();
      cmp("addr_present", 32'(ld_addr), 32'(exp_addr));
      cmp("ready_open", 32'(ld_ready), 32'd1);
      ld_valid = 1'b1;
      ld_data  = b;
      acc_q.push_back(exp_addr);
      if (exp_done) done_exp++;
      tick();
      ld_valid = 1'b0;
   endtask

   task automatic send_byte(input int idx, input logic [7:0] b, input int gap);
      bit last;
      last = (idx == 15);
`ifdef PROG_CHECKSUM_EN
      last = 1'b0;
`endif
      model[idx] = b;
      send_raw(4'(idx), b, gap, last);
   endtask

   // gap < 0 selects a random 0..2 idle cycles before each byte.
   task automatic full_load(input int gap, input bit poke, input bit cs_good);
      logic [7:0] sum;
      logic [7:0] csb;
      sum = '0;
      for (int i = 0; i < 16; i++) begin
         send_byte(i, pbuf[i], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
         sum = sum + pbuf[i];
      end
`ifdef PROG_CHECKSUM_EN
      cmp("check_busy", 32'(ld_busy), 32'd1);
      csb = cs_good ? sum : sum + 8'd1;
      send_raw(4'd0, csb, (gap < 0) ? 0 : gap, cs_good);
      if (!cs_good) model_default();
      cmp("check_err", 32'(ld_err), cs_good ? 32'd0 : 32'd1);
`else
      csb = sum;
      if (cs_good && csb != sum) $display("checksum note");
`endif
      hold_check("load", poke);
   endtask

   task automatic read_all();
      for (int i = 0; i < 16; i++) begin
         pc = 4'(i);
         rd_q.push_back(model[i]);
         rd_req = 1'b1;
         tick();
      end
      rd_req = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------------
   initial begin
      model_default();
      #2;
      do_reset();
      read_all();

      // Bytes 00..0F with ld_valid every other cycle, ld_start poked in HOLD
      wait_run();
      start_load(1'b0);
      for (int i = 0; i < 16; i++) pbuf[i] = 8'(i);
      full_load(1, 1'b1, 1'b1);
      read_all();

      // Interrupted after 5 bytes, restart with a byte offered on ld_start
      wait_run();
      start_load(1'b0);
      for (int i = 0; i < 5; i++) send_byte(i, 8'($urandom), 0);
      start_load(1'b1);
      for (int i = 0; i < 16; i++) pbuf[i] = 8'hF0 + 8'(i);
      full_load(0, 1'b0, 1'b1);
      read_all();

      // Reset after 7 bytes discards the partial program
      wait_run();
      start_load(1'b0);
      for (int i = 0; i < 7; i++) send_byte(i, 8'($urandom), 1);
      do_reset();
      read_all();

`ifdef PROG_CHECKSUM_EN
      wait_run();
      start_load(1'b0);
      for (int i = 0; i < 16; i++) pbuf[i] = 8'h10;
      full_load(0, 1'b0, 1'b1);
      read_all();
      wait_run();
      start_load(1'b0);
      full_load(0, 1'b0, 1'b0);
      read_all();
`endif

      // Randomized loads, interruptions and resets
      for (int it = 0; it < 10; it++) begin
         int mode;
         int k;
         mode = int'($urandom_range(0, 3));
         k    = int'($urandom_range(1, 14));
         wait_run();
         start_load(1'($urandom));
         if (mode == 1) begin
            for (int i = 0; i < k; i++) send_byte(i, 8'($urandom), int'($urandom_range(0, 2)));
            do_reset();
         end else begin
            if (mode == 0) begin
               for (int i = 0; i < k; i++) send_byte(i, 8'($urandom), int'($urandom_range(0, 2)));
               start_load(1'($urandom));
            end
            for (int i = 0; i < 16; i++) pbuf[i] = 8'($urandom);
            full_load(-1, 1'($urandom), 1'($urandom));
         end
         read_all();
      end

      tick();
      tick();
      cmp("acc_queue_empty", 32'(acc_q.size()), 32'd0);
      cmp("done_all_seen", 32'(done_exp), 32'd0);
      cmp("rd_queue_empty", 32'(rd_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no completion expected finish before 500000ns");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
